// File: rtl/grid_server_pkg.sv
// Shared definitions for the grid server: default grid geometry, cell codes
// and the FSM state encoding.
package grid_server_pkg;

  localparam int unsigned GRID_XW = 6;
  localparam int unsigned GRID_YW = 5;
  localparam int unsigned CELL_W  = 3;

  localparam int unsigned GRID_W = 1 << GRID_XW;  // 64 columns
  localparam int unsigned GRID_H = 1 << GRID_YW;  // 32 rows

  localparam logic [CELL_W-1:0] CELL_EMPTY = 3'b000;
  localparam logic [CELL_W-1:0] CELL_WALL  = 3'b001;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/grid_server_if.sv
// Client-side bus of the grid server.
//   ready               : server finished its init sweep and is serving
//   p_* / r_*           : read clients 0 (player updater) and 1 (renderer):
//                         req + coordinates in, ack / valid / cell type out
//   wr_en/wr_x/wr_y/... : map-edit write port (no handshake)
// master = client side, slave = grid_server side.
interface grid_server_if #(
  parameter int unsigned XW = grid_server_pkg::GRID_XW,
  parameter int unsigned YW = grid_server_pkg::GRID_YW,
  parameter int unsigned CW = grid_server_pkg::CELL_W
);

  logic          ready;

  logic          p_req;
  logic [XW-1:0] p_grid_x;
  logic [YW-1:0] p_grid_y;
  logic          p_ack;
  logic          p_valid;
  logic [CW-1:0] p_grid_out;

  logic          r_req;
  logic [XW-1:0] r_grid_x;
  logic [YW-1:0] r_grid_y;
  logic          r_ack;
  logic          r_valid;
  logic [CW-1:0] r_grid_out;

  logic          wr_en;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [CW-1:0] wr_data;

  modport master (
    input  ready,
    output p_req, p_grid_x, p_grid_y,
    input  p_ack, p_valid, p_grid_out,
    output r_req, r_grid_x, r_grid_y,
    input  r_ack, r_valid, r_grid_out,
    output wr_en, wr_x, wr_y, wr_data
  );

  modport slave (
    output ready,
    input  p_req, p_grid_x, p_grid_y,
    output p_ack, p_valid, p_grid_out,
    input  r_req, r_grid_x, r_grid_y,
    output r_ack, r_valid, r_grid_out,
    input  wr_en, wr_x, wr_y, wr_data
  );

endinterface

// File: rtl/grid_ram.sv
// Single-port synchronous cell RAM. A write cycle stores wdata_i; any other
// cycle reads addr_i into rdata_o (1-cycle latency, held until the next read).
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : cell address {y, x}
//   wdata_i : cell to write
//   rdata_o : registered read data
module grid_ram #(
  parameter int unsigned AddrW = 11,
  parameter int unsigned DataW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] rdata_q;

  // Contents are deliberately not reset; the server's init sweep rewrites them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/grid_server.sv
// Tile-map server: after reset it sweeps the whole RAM (walls on the border,
// empty inside), then serves two read clients round-robin and one write port
// that always has priority. One RAM access per cycle.
//   clock : clock, all logic on posedge
//   reset : asynchronous active-high reset
//   bus   : grid_server_if slave (ready, two read clients, write port)
module grid_server #(
  parameter int unsigned       GRID_XW   = grid_server_pkg::GRID_XW,
  parameter int unsigned       GRID_YW   = grid_server_pkg::GRID_YW,
  parameter int unsigned       CELL_W    = grid_server_pkg::CELL_W,
  parameter logic [CELL_W-1:0] WALL_CODE = grid_server_pkg::CELL_WALL
) (
  input logic         clock,
  input logic         reset,
  grid_server_if.slave bus
);

  import grid_server_pkg::*;

  localparam int unsigned AW = GRID_XW + GRID_YW;

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              ptr_q;     // last granted read client
  logic              ready_q;
  logic              p_valid_q, r_valid_q;
  logic [CELL_W-1:0] p_hold_q, r_hold_q;

  logic              p_grant, r_grant;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [CELL_W-1:0] ram_wdata, ram_rdata;

  logic [GRID_XW-1:0] sweep_x;
  logic [GRID_YW-1:0] sweep_y;
  logic               sweep_border;

  assign sweep_x      = cnt_q[GRID_XW-1:0];
  assign sweep_y      = cnt_q[AW-1:GRID_XW];
  assign sweep_border = (sweep_x == '0) || (&sweep_x) || (sweep_y == '0) || (&sweep_y);

  // Grants are decided combinationally from the current requests so a client
  // that drops req on seeing ack is never granted twice.
  always_comb begin
    p_grant   = 1'b0;
    r_grant   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cnt_q;
    ram_wdata = '0;
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_wdata = sweep_border ? WALL_CODE : '0;
    end else if (bus.wr_en) begin
      ram_we    = 1'b1;
      ram_addr  = {bus.wr_y, bus.wr_x};
      ram_wdata = bus.wr_data;
    end else if (bus.p_req && bus.r_req) begin
      // Tie goes to whichever client was not granted last.
      p_grant = ptr_q;
      r_grant = !ptr_q;
    end else begin
      p_grant = bus.p_req;
      r_grant = bus.r_req;
    end
    if (p_grant) begin
      ram_addr = {bus.p_grid_y, bus.p_grid_x};
    end else if (r_grant) begin
      ram_addr = {bus.r_grid_y, bus.r_grid_x};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      ready_q   <= 1'b0;
      p_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      p_hold_q  <= '0;
      r_hold_q  <= '0;
    end else begin
      p_valid_q <= p_grant;
      r_valid_q <= r_grant;
      if (p_valid_q) p_hold_q <= ram_rdata;
      if (r_valid_q) r_hold_q <= ram_rdata;
      if (p_grant) begin
        ptr_q <= 1'b0;
      end else if (r_grant) begin
        ptr_q <= 1'b1;
      end
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun:   ready_q <= 1'b1;
        default: state_q <= StInit;
      endcase
    end
  end

  grid_ram #(
    .AddrW(AW),
    .DataW(CELL_W)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign bus.ready      = ready_q;
  assign bus.p_ack      = p_grant;
  assign bus.r_ack      = r_grant;
  assign bus.p_valid    = p_valid_q;
  assign bus.r_valid    = r_valid_q;
  // RAM data is live in the valid cycle and captured for holding afterwards.
  assign bus.p_grid_out = p_valid_q ? ram_rdata : p_hold_q;
  assign bus.r_grid_out = r_valid_q ? ram_rdata : r_hold_q;

endmodule

// File: tb/tb_grid_server.sv
// Randomised scoreboard bench for grid_server. A behavioural map model
// predicts ready, grants and read data; the monitor checks valid/data.
module tb_grid_server;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  grid_server_if bus ();

  grid_server dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [2:0] model [2048];
  logic [2:0] exp_p [$];
  logic [2:0] exp_r [$];
  logic [2:0] last_p = 3'b000;
  logic [2:0] last_r = 3'b000;
  int  checks = 0;
  int  errors = 0;
  int  sweep_left = 0;
  bit  last_gnt = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int addr_of(input int x, input int y);
    return y * 64 + x;
  endfunction

  task automatic init_model();
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        model[addr_of(x, y)] = (x == 0 || x == 63 || y == 0 || y == 31) ? 3'b001 : 3'b000;
      end
    end
  endtask

  // Called at posedge+1 with this cycle's inputs driven; returns predicted grants.
  task automatic step(output bit gp, output bit gr);
    bit rdy;
    rdy = (sweep_left == 0);
    gp  = 1'b0;
    gr  = 1'b0;
    if (!rdy) begin
      sweep_left--;
    end else if (bus.wr_en) begin
      model[addr_of(int'(bus.wr_x), int'(bus.wr_y))] = bus.wr_data;
    end else if (bus.p_req && bus.r_req) begin
      if (last_gnt) gp = 1'b1;
      else gr = 1'b1;
    end else begin
      gp = bus.p_req;
      gr = bus.r_req;
    end
    if (gp) begin
      exp_p.push_back(model[addr_of(int'(bus.p_grid_x), int'(bus.p_grid_y))]);
      last_gnt = 1'b0;
    end
    if (gr) begin
      exp_r.push_back(model[addr_of(int'(bus.r_grid_x), int'(bus.r_grid_y))]);
      last_gnt = 1'b1;
    end
    @(negedge clock);
    chk("ready", bus.ready, rdy);
    chk("p_ack", bus.p_ack, gp);
    chk("r_ack", bus.r_ack, gr);
    @(posedge clock);
    #1;
  endtask

  // Asserts reset now, checks cleared outputs, releases at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    bus.p_req = 1'b0;
    bus.r_req = 1'b0;
    bus.wr_en = 1'b0;
    exp_p.delete();
    exp_r.delete();
    last_p   = 3'b000;
    last_r   = 3'b000;
    last_gnt = 1'b1;
    init_model();
    #1;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_p_valid", bus.p_valid, 1'b0);
    chk("rst_r_valid", bus.r_valid, 1'b0);
    chk("rst_p_grid_out", bus.p_grid_out, 3'b000);
    chk("rst_r_grid_out", bus.r_grid_out, 3'b000);
    chk("rst_p_ack", bus.p_ack, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    sweep_left = 2048;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.p_valid) begin
        if (exp_p.size() == 0) begin
          chk("p_valid_unexpected", bus.p_valid, 1'b0);
        end else begin
          last_p = exp_p.pop_front();
          chk("p_grid_out", bus.p_grid_out, last_p);
        end
      end else begin
        chk("p_grid_out_hold", bus.p_grid_out, last_p);
      end
      if (bus.r_valid) begin
        if (exp_r.size() == 0) begin
          chk("r_valid_unexpected", bus.r_valid, 1'b0);
        end else begin
          last_r = exp_r.pop_front();
          chk("r_grid_out", bus.r_grid_out, last_r);
        end
      end else begin
        chk("r_grid_out_hold", bus.r_grid_out, last_r);
      end
    end
  end

  initial begin
    bit gp, gr;
    int n;
    bus.p_req = 1'b0; bus.p_grid_x = '0; bus.p_grid_y = '0;
    bus.r_req = 1'b0; bus.r_grid_x = '0; bus.r_grid_y = '0;
    bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    @(posedge clock);
    #1;
    do_reset();

    // Request held through the sweep: first ack in the cycle ready rises.
    bus.p_req = 1'b1; bus.p_grid_x = 6'd0; bus.p_grid_y = 5'd0;
    n = 0;
    gp = 1'b0;
    while (!gp && n < 3000) begin
      step(gp, gr);
      if (!gp) n++;
    end
    chk("first_ack_cycle", n, 2048);
    bus.p_grid_x = 6'd63; bus.p_grid_y = 5'd31;
    step(gp, gr);
    bus.p_grid_x = 6'd5; bus.p_grid_y = 5'd5;
    step(gp, gr);
    bus.p_req = 1'b0;
    repeat (2) step(gp, gr);

    // Sole requester at (10,7).
    bus.p_req = 1'b1; bus.p_grid_x = 6'd10; bus.p_grid_y = 5'd7;
    step(gp, gr);
    bus.p_req = 1'b0;
    repeat (2) step(gp, gr);

    // Write wins over a read of the same cell; the read then sees new data.
    bus.wr_en = 1'b1; bus.wr_x = 6'd12; bus.wr_y = 5'd3; bus.wr_data = 3'b010;
    bus.p_req = 1'b1; bus.p_grid_x = 6'd12; bus.p_grid_y = 5'd3;
    step(gp, gr);
    bus.wr_en = 1'b0;
    step(gp, gr);
    bus.p_req = 1'b0;
    repeat (2) step(gp, gr);

    // Reset while a valid is pending.
    bus.p_req = 1'b1; bus.p_grid_x = 6'd20; bus.p_grid_y = 5'd9;
    @(negedge clock);
    chk("midread_ack", bus.p_ack, 1'b1);
    #2;
    do_reset();

    // Reset in the middle of the sweep restarts it in full.
    repeat (1000) step(gp, gr);
    do_reset();
    repeat (2049) step(gp, gr);

    // Both clients held: p first, then strict alternation.
    bus.p_req = 1'b1; bus.p_grid_x = 6'd1;  bus.p_grid_y = 5'd1;
    bus.r_req = 1'b1; bus.r_grid_x = 6'd62; bus.r_grid_y = 5'd30;
    for (int i = 0; i < 6; i++) begin
      step(gp, gr);
      chk("alt_order_p", gp, (i % 2 == 0));
    end
    bus.p_req = 1'b0;
    bus.r_req = 1'b0;
    repeat (2) step(gp, gr);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.p_req && $urandom_range(0, 1) == 0) begin
        bus.p_req = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          bus.p_grid_x = 6'($urandom_range(0, 3)); bus.p_grid_y = 5'($urandom_range(0, 3));
        end else begin
          bus.p_grid_x = 6'($urandom_range(0, 63)); bus.p_grid_y = 5'($urandom_range(0, 31));
        end
      end
      if (!bus.r_req && $urandom_range(0, 1) == 0) begin
        bus.r_req = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          bus.r_grid_x = 6'($urandom_range(0, 3)); bus.r_grid_y = 5'($urandom_range(0, 3));
        end else begin
          bus.r_grid_x = 6'($urandom_range(0, 63)); bus.r_grid_y = 5'($urandom_range(0, 31));
        end
      end
      bus.wr_en = ($urandom_range(0, 5) == 0);
      bus.wr_data = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        bus.wr_x = 6'($urandom_range(0, 3)); bus.wr_y = 5'($urandom_range(0, 3));
      end else begin
        bus.wr_x = 6'($urandom_range(0, 63)); bus.wr_y = 5'($urandom_range(0, 31));
      end
      step(gp, gr);
      if (gp) bus.p_req = 1'b0;
      if (gr) bus.r_req = 1'b0;
    end

    bus.p_req = 1'b0;
    bus.r_req = 1'b0;
    bus.wr_en = 1'b0;
    repeat (3) step(gp, gr);
    chk("p_queue_drained", exp_p.size(), 0);
    chk("r_queue_drained", exp_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_server.md
GRID_SERVER -- requirements
Module: grid_server

Interface
REQ-001 SHALL have params: GRID_XW, default 6, grid x width; GRID_YW, default 5, grid y width; CELL_W, default 3, cell type width; WALL_CODE, default 3'b001, border cell value.
REQ-002 SHALL have port: clock  in  1  single clock, all logic on posedge.
REQ-003 SHALL have port: reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: ready  out  1  high when init sweep complete and serving.
REQ-005 SHALL have ports p_req in 1, p_grid_x in 6, p_grid_y in 5: client 0 (player updater) read request and cell.
REQ-006 SHALL have ports p_ack out 1, p_valid out 1, p_grid_out out 3: client 0 grant pulse, data-valid pulse, cell type.
REQ-007 SHALL have ports r_req in 1, r_grid_x in 6, r_grid_y in 5: client 1 (renderer) read request and cell.
REQ-008 SHALL have ports r_ack out 1, r_valid out 1, r_grid_out out 3: client 1 grant, valid, data.
REQ-009 SHALL have ports wr_en in 1, wr_x in 6, wr_y in 5, wr_data in 3: map edit (doors, pickups).

Function
REQ-010 SHALL store 64x32 cells of 3 bits, address = {y, x} (11 bits), in synchronous RAM with 1-cycle read latency.
REQ-011 SHALL run FSM states INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-012 In INIT, SHALL write one address per cycle, counter 0..2047: WALL_CODE if x==0, x==63, y==0 or y==31, else 3'b000.
REQ-013 SHALL go INIT->RUN the cycle after address 2047 is written; ready rises on entering RUN (2048 cycles after reset release).
REQ-014 In INIT, SHALL ignore p_req, r_req, wr_en: no ack, no valid, no write.
REQ-015 In RUN, SHALL perform at most one RAM access per cycle; priority: wr_en > reads.
REQ-016 Reads SHALL be arbitrated round-robin: last-granted pointer toggles on each read grant; sole requester granted immediately; on tie the client not granted last wins; pointer = client 1 after reset (client 0 wins first tie).
REQ-017 Grant SHALL pulse *_ack for one cycle (cycle N), sampling that client's coordinates in N; *_valid SHALL pulse in N+1 with *_grid_out holding the cell.
REQ-018 *_grid_out SHALL hold last read value until next valid for that client; 0 after reset.
REQ-019 Clients hold *_req and coordinates until ack; requester held back by a write or lost arbitration SHALL get no ack that cycle and stays pending.
REQ-020 A client keeping req high after ack SHALL be treated as a new request; the other requester still alternates per REQ-016.
REQ-021 A read the cycle after a write to the same cell SHALL return new data; wr_en has no ack and takes effect when sampled in RUN.
REQ-022 Read latency SHALL be exactly 1 cycle from ack to valid, no bubbles with back-to-back grants.

Reset
REQ-023 Asserting reset, including mid-sweep or mid-read, SHALL immediately clear ready, p_ack, r_ack, p_valid, r_valid, p_grid_out, r_grid_out, arbitration pointer (client 1) and sweep counter, state INIT.
REQ-024 An in-flight read at reset SHALL produce no valid; RAM contents are not reset but rewritten by the sweep.

Structure
REQ-025 Shared package SHALL hold GRID_XW, GRID_YW, CELL_W, CELL_EMPTY (3'b000), CELL_WALL (3'b001), grid dimensions 64/32, FSM state encoding.
REQ-026 RAM SHALL be one sub-module grid_ram (single-port, synchronous write and read, 2048x3); arbiter and FSM stay in grid_server.

Verification
REQ-027 Reset release, no requests -> ready low 2048 cycles then high; read (0,0)=3'b001, (63,31)=3'b001, (5,5)=3'b000.
REQ-028 p_req at (10,7) alone in RUN -> p_ack cycle N, p_valid N+1, p_grid_out=3'b000; r_* silent.
REQ-029 p_req and r_req held continuously -> acks alternate p,r,p,r starting with p; each valid one cycle after its ack.
REQ-030 wr_en (12,3) data 3'b010 while p_req (12,3) -> write first, p_ack next cycle, p_grid_out=3'b010.
REQ-031 Reset asserted at sweep count 1000 and during pending valid -> valid suppressed, ready low, full 2048-cycle sweep restarts.
REQ-032 Requests during INIT -> no ack until ready; first ack in cycle ready rises.
